// File: rtl/nibble_serial_add_ctrl.sv
// Multi-precision add/subtract sequencer driving one shared 4-bit ripple-carry adder,
// one nibble per clock, least-significant nibble first.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op_sub,
  input  logic                 cin,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 ovf,
  output logic [3:0]           adder_a,
  output logic [3:0]           adder_b,
  output logic                 adder_cin,
  input  logic [3:0]           adder_s,
  input  logic                 adder_cout
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             last;

  assign last = (idx == IDX_W'(NIBBLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The adder inputs are only driven while a nibble is being processed.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    adder_a    = 4'h0;
    adder_b    = 4'h0;
    adder_cin  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        adder_a   = a_reg[{idx, 2'b00} +: 4];
        adder_b   = b_reg[{idx, 2'b00} +: 4];
        adder_cin = carry;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is stored inverted and the carry seeded with 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a_in;
            b_reg <= op_sub ? ~b_in : b_in;
            carry <= op_sub | cin;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IDX_W'(n)) result[4*n +: 4] <= adder_s;
          end
          carry <= adder_cout;
          if (last) begin
            cout <= adder_cout;
            ovf  <= (a_reg[W-1] == b_reg[W-1]) && (adder_s[3] != a_reg[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized and directed bench for nibble_serial_add_ctrl with a behavioural 4-bit adder.
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, cout, ovf, adder_cin, adder_cout;
  logic [W-1:0] result;
  logic [3:0]   adder_a, adder_b, adder_s;

  int passed = 0;
  int total  = 0;

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .cin(cin),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .result(result),
    .cout(cout), .ovf(ovf), .adder_a(adder_a), .adder_b(adder_b),
    .adder_cin(adder_cin), .adder_s(adder_s), .adder_cout(adder_cout)
  );

  // Shared 4-bit ripple-carry adder
  assign {adder_cout, adder_s} = {1'b0, adder_a} + {1'b0, adder_b} + {4'b0, adder_cin};

  always #5 clk = ~clk;

  // Reference: whole-word arithmetic, returns {cout, ovf, result}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub, input logic ci);
    logic [W:0]   full;
    logic [W-1:0] res;
    logic         v;
    if (sub) begin
      full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      res  = full[W-1:0];
      v    = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
      res  = full[W-1:0];
      v    = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
    end
    return {full[W], v, res};
  endfunction

  // Starts one operation in the next cycle and waits (bounded) for done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic ci, output logic [W+1:0] got, output int lat);
    @(negedge clk);
    a_in = a; b_in = b; op_sub = sub; cin = ci; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    got = {cout, ovf, result};
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, cout, ovf} !== 4'b0) $display("[TB] FAIL reset_flags got=%b want=0000", {busy, done, cout, ovf});
    else passed++;
    total++;
    if (result !== '0) $display("[TB] FAIL reset_result got=%h want=0000", result);
    else passed++;
    total++;
    if ({adder_a, adder_b, adder_cin} !== 9'b0) $display("[TB] FAIL reset_adder got=%h want=000", {adder_a, adder_b, adder_cin});
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] da[6] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h0005, 16'h8000, 16'h7FFF};
    logic [W-1:0] db[6] = '{16'h0FFF, 16'h0001, 16'h0000, 16'h0007, 16'h0001, 16'h0001};
    logic         ds[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic         dc[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [W+1:0] want[6] = '{{2'b00, 16'h2233}, {2'b10, 16'h0000}, {2'b00, 16'h0001},
                              {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}, {2'b01, 16'h8000}};
    logic [W+1:0] got;
    int lat;
    $display("[TB] test_directed");
    for (int i = 0; i < 6; i++) begin
      run_op(da[i], db[i], ds[i], dc[i], got, lat);
      total++;
      if (lat != NIBBLES + 1) $display("[TB] FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, NIBBLES + 1);
      else passed++;
      total++;
      if (got !== want[i]) $display("[TB] FAIL directed_value[%0d] got={cout,ovf,res}=%h want=%h", i, got, want[i]);
      else passed++;
    end
    @(negedge clk);
    total++;
    if ({busy, done, adder_a, adder_b, adder_cin} !== 11'b0) $display("[TB] FAIL idle_after_op got=%h want=000", {busy, done, adder_a, adder_b, adder_cin});
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic         s, c;
    logic [W+1:0] got, want;
    int lat;
    $display("[TB] test_back_to_back");
    for (int i = 0; i < 25; i++) begin
      a = W'($urandom); b = W'($urandom); s = 1'($urandom); c = 1'($urandom);
      want = model(a, b, s, c);
      run_op(a, b, s, c, got, lat);
      total++;
      if (lat != NIBBLES + 1 || got !== want)
        $display("[TB] FAIL random[%0d] a=%h b=%h sub=%b cin=%b got=%h lat=%0d want=%h lat=%0d", i, a, b, s, c, got, lat, want, NIBBLES + 1);
      else passed++;
    end
  endtask

  task automatic test_ignore_start();
    logic [W+1:0] want;
    int dones = 0;
    $display("[TB] test_ignore_start");
    want = model(16'h4321, 16'h1111, 1'b1, 1'b0);
    @(negedge clk);
    a_in = 16'h4321; b_in = 16'h1111; op_sub = 1'b1; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a_in = 16'hAAAA; b_in = 16'h5555; op_sub = 1'b0; cin = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        start = 1'b1;
      end else begin
        start = (c == 2);
      end
    end
    start = 1'b0;
    total++;
    if (dones != 1) $display("[TB] FAIL ignore_done_count got=%0d want=1", dones);
    else passed++;
    total++;
    if ({cout, ovf, result} !== want) $display("[TB] FAIL ignore_result got=%h want=%h", {cout, ovf, result}, want);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("[TB] FAIL ignore_busy got=%b want=0", busy);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    logic [W+1:0] got;
    int lat;
    int dones = 0;
    $display("[TB] test_reset_midrun");
    @(negedge clk);
    a_in = 16'h1234; b_in = 16'h0FFF; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, cout, ovf, result, adder_a, adder_b, adder_cin} !== '0)
      $display("[TB] FAIL midrun_reset got=%h want=0", {busy, done, cout, ovf, result, adder_a, adder_b, adder_cin});
    else passed++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++;
    if (dones != 0) $display("[TB] FAIL midrun_no_done got=%0d want=0", dones);
    else passed++;
    run_op(16'h00AA, 16'h0055, 1'b0, 1'b0, got, lat);
    total++;
    if (got !== {2'b00, 16'h00FF} || lat != NIBBLES + 1)
      $display("[TB] FAIL midrun_recover got=%h lat=%0d want=%h lat=%0d", got, lat, {2'b00, 16'h00FF}, NIBBLES + 1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
